// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back a multiplexed active-low 7-segment bus and
// rebuilds one complete scan frame (value, dp, blank, err per digit). The
// frame is then presented on a valid/ready output.
// Optional build macro: SEG_SCAN_DECODER_HEX_EN (hex letters A..F decode as
// valid values instead of errors).
module seg_scan_decoder #(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_digits,
    output logic [DIGITS-1:0]     out_dp,
    output logic [DIGITS-1:0]     out_blank,
    output logic [DIGITS-1:0]     out_err,
    output logic                  overflow
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned NZ_W  = 5;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_REACH  = CNT_W'(STABLE_CYCLES - 1);

    // Decode a..g into {value[3:0], blank, err}; dp is handled separately.
    function automatic logic [5:0] decode_seg(input logic [6:0] p);
        logic [5:0] r;
        r = {4'hF, 1'b0, 1'b1};
        case (p)
            7'b0000001: r = {4'h0, 2'b00};
            7'b1001111: r = {4'h1, 2'b00};
            7'b0010010: r = {4'h2, 2'b00};
            7'b0000110: r = {4'h3, 2'b00};
            7'b1001100: r = {4'h4, 2'b00};
            7'b0100100: r = {4'h5, 2'b00};
            7'b0100000: r = {4'h6, 2'b00};
            7'b0001111: r = {4'h7, 2'b00};
            7'b0000000: r = {4'h8, 2'b00};
            7'b0000100: r = {4'h9, 2'b00};
            7'b1111111: r = {4'hF, 2'b10};
`ifdef SEG_SCAN_DECODER_HEX_EN
            7'b0001000: r = {4'hA, 2'b00};
            7'b1100000: r = {4'hB, 2'b00};
            7'b0110001: r = {4'hC, 2'b00};
            7'b1000010: r = {4'hD, 2'b00};
            7'b0110000: r = {4'hE, 2'b00};
            7'b0111000: r = {4'hF, 2'b00};
`else
`endif
            default:    r = {4'hF, 2'b01};
        endcase
        return r;
    endfunction

    logic [7:0]              seg_q;
    logic [DIGITS-1:0]       an_q;
    logic [7:0]              prev_seg;
    logic [DIGITS-1:0]       prev_an;
    logic [CNT_W-1:0]        cnt;
    logic [DIGITS-1:0]       mask;
    logic [4*DIGITS-1:0]     slot_val;
    logic [DIGITS-1:0]       slot_dp;
    logic [DIGITS-1:0]       slot_blank;
    logic [DIGITS-1:0]       slot_err;

    logic [NZ_W-1:0]         nzero_c;
    logic [IDX_W-1:0]        idx_c;
    logic                    single_c;
    logic                    match_c;
    logic                    reach_c;
    logic                    capture_c;
    logic                    full_c;
    logic [CNT_W-1:0]        cnt_next_c;
    logic [5:0]              dec_c;

    // Anode analysis, stability tracking and capture decision.
    always_comb begin
        nzero_c = '0;
        idx_c   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                nzero_c = nzero_c + NZ_W'(1);
                idx_c   = IDX_W'(i);
            end
        end
        single_c = (nzero_c == NZ_W'(1));
        match_c  = (an_q == prev_an) && (seg_q == prev_seg);

        cnt_next_c = '0;
        if (single_c) begin
            if (!match_c)            cnt_next_c = CNT_W'(1);
            else if (cnt == CNT_MAX) cnt_next_c = cnt;
            else                     cnt_next_c = cnt + CNT_W'(1);
        end

        // Fires only on the sample where the counter arrives at the threshold.
        reach_c   = single_c && (match_c ? (cnt == CNT_REACH) : (STABLE_CYCLES == 1));
        capture_c = reach_c && !mask[idx_c];
        full_c    = &mask;
        dec_c     = decode_seg(seg_q[7:1]);
    end

    // Input stage plus previous-sample and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q    <= '0;
            an_q     <= '0;
            prev_seg <= '0;
            prev_an  <= '0;
            cnt      <= '0;
        end else begin
            seg_q    <= seg;
            an_q     <= an;
            prev_seg <= seg_q;
            prev_an  <= an_q;
            cnt      <= cnt_next_c;
        end
    end

    // Per-digit slots and capture mask; mask clears once the frame is complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask       <= '0;
            slot_val   <= '0;
            slot_dp    <= '0;
            slot_blank <= '0;
            slot_err   <= '0;
        end else if (full_c) begin
            mask <= '0;
        end else if (capture_c) begin
            mask[idx_c]               <= 1'b1;
            slot_val[4*idx_c +: 4]    <= dec_c[5:2];
            slot_blank[idx_c]         <= dec_c[1];
            slot_err[idx_c]           <= dec_c[0];
            slot_dp[idx_c]            <= ~seg_q[0];
        end
    end

    // Output frame register with valid/ready handshake and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_digits <= '0;
            out_dp     <= '0;
            out_blank  <= '0;
            out_err    <= '0;
            overflow   <= 1'b0;
        end else if (full_c && (!out_valid || out_ready)) begin
            out_valid  <= 1'b1;
            out_digits <= slot_val;
            out_dp     <= slot_dp;
            out_blank  <= slot_blank;
            out_err    <= slot_err;
        end else begin
            if (full_c)                 overflow  <= 1'b1;
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads back a multiplexed, active-low 7-segment display bus (segment lines plus digit anodes) and recovers the per-digit BCD values, decimal points, blank flags and error flags.
- Sits on the display side of the board I/O as a monitor/self-check for the display driver path, or as a receiver when the display bus is looped back.
- Collects one complete scan frame (every digit captured once), then presents it on a valid/ready output.

Parameters:
- DIGITS, 8, number of multiplexed digits (anode lines); range 1..16.
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit is accepted; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- seg  in  8  segment bus, active-low (0 = lit): bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp
- an  in  DIGITS  digit select, active-low; bit i selects digit i
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts frame
- out_digits  out  4*DIGITS  decoded value per digit; digit i is at [4i+3:4i]
- out_dp  out  DIGITS  1 = decimal point lit
- out_blank  out  DIGITS  1 = all of a..g off
- out_err  out  DIGITS  1 = a..g pattern not in the decode table
- overflow  out  1  sticky: a completed frame was dropped

Behaviour:
- Reset, asynchronous: all outputs 0; capture mask, stability counter, previous-sample registers and the slot register all clear.
- Input sampling: seg and an are registered once on entry (1-cycle input stage). All comparisons use the registered values.
- Digit-select check: a sample is "single" when exactly one an bit is 0. Zero or multiple active anodes: stability counter := 0 and nothing is captured.
- Stability tracking: when a sample is single and its anode index and seg equal the previous sample, the counter increments and saturates. Any change in anode or seg sets the counter to 1 for a single sample, or 0 otherwise.
- Capture: when the counter reaches STABLE_CYCLES and capture-mask bit i is clear, decode seg[7:1] into slot i, latch dp = ~seg[0], and set mask bit i. Each digit is captured at most once per frame; later stable samples of a captured digit are ignored.
- Decode of a..g (bit7..bit1; dp ignored), giving value, blank, err:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111 → value 4'hF, blank=1, err=0.
  - Any other pattern → value 4'hF, blank=0, err=1.
- Frame complete when the mask is all ones.
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: load the outputs from the slots, out_valid:=1, clear the mask.
  - Otherwise: drop the frame, set overflow (cleared only by rst), clear the mask.
- Handshake: out_valid holds, with stable data, until a cycle with out_ready=1. That cycle transfers the frame; out_valid drops next cycle unless a new frame loads at the same time.
- Latency: a digit that is stable from cycle t is captured at t+STABLE_CYCLES; out_valid rises 1 cycle after the capture that completes the frame.
- Reset mid-frame: partial captures are discarded; the first frame after reset needs every digit again.
- STABLE_CYCLES=1: every single sample qualifies immediately.

Optional Feature:
- Macro: SEG_SCAN_DECODER_HEX_EN.
- Defined: hex letters also decode, with err=0: 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F.
- Undefined: those patterns decode as errors (value 4'hF, err=1).
- Blank handling is identical either way; software distinguishes a blank digit from a true F by out_blank.

Test Plan:
- DIGITS=2, STABLE_CYCLES=4. Hold an=2'b10, seg=8'b0000_1101 for 6 cycles, then an=2'b01, seg=8'b1001_1110 for 6 cycles → out_valid=1, out_digits=8'h13, out_dp=2'b10, out_err=0, out_blank=0.
- Digit 0 held only 3 cycles, then anode switches → not captured; out_valid stays 0 until digit 0 is later held ≥4 cycles.
- an=2'b00 with stable seg for 10 cycles → no capture, mask unchanged.
- Two full frames (values 0x42, then 0x77) with out_ready=0 → outputs still show 0x42, overflow=1. Assert out_ready for 1 cycle → out_valid=0 next cycle.
- seg=8'b1111_1111 → blank=1, value F. seg=8'b0001_0001 → err=1 without SEG_SCAN_DECODER_HEX_EN; value A, err=0 with it.
- Assert rst mid-frame after digit 0 is captured → all outputs 0, and a frame needs both digits again.
